rotate_right_seq: RTL

//  Multi-cycle right-shift/rotate unit for the 16-bit datapath; pairs with the

---
 rtl/rotate_right_seq_pkg.sv | 19 +
 rtl/shift_right_step.sv | 22 ++
 rtl/rotate_right_seq.sv | 85 ++++++++
 3 files changed

// File: rtl/rotate_right_seq_pkg.sv
// Shared encodings for the multi-cycle right shifter: operation codes and FSM states.
package rotate_right_seq_pkg;

  // Operation encodings on the op port; 2'b11 is an alias for rotate.
  typedef enum logic [1:0] {
    OP_ROR     = 2'b00,
    OP_SRL     = 2'b01,
    OP_SRA     = 2'b10,
    OP_ROR_ALT = 2'b11
  } op_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_right_step.sv
// Combinational one-position right step: rotate, logical or arithmetic shift.
module shift_right_step
  import rotate_right_seq_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] acc,
  input  logic [1:0]   op,
  output logic [N-1:0] nxt
);

  // Select fill bit by operation; unknown/alias codes rotate.
  always_comb begin
    nxt = {acc[0], acc[N-1:1]};
    case (op)
      OP_SRL:  nxt = {1'b0, acc[N-1:1]};
      OP_SRA:  nxt = {acc[N-1], acc[N-1:1]};
      default: nxt = {acc[0], acc[N-1:1]};
    endcase
  end

endmodule

// File: rtl/rotate_right_seq.sv
// Multi-cycle right shift/rotate unit, one bit per clock, start/busy/done handshake.
module rotate_right_seq
  import rotate_right_seq_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned C = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] In,
  input  logic [C-1:0] Cnt,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Out
);

  state_t       state, state_nx;
  logic [N-1:0] acc;
  logic [C-1:0] rem;
  logic [1:0]   op_q;
  logic [N-1:0] out_q;
  logic [N-1:0] step_nx;

  shift_right_step #(.N(N)) u_step (
    .acc (acc),
    .op  (op_q),
    .nxt (step_nx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (Cnt != '0) ? SHIFT : DONE;
      SHIFT:   if (rem == C'(1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture operands, shift, and load the result.
  // The result register is written on the edge that enters DONE so that Out
  // is already valid during the single cycle in which done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      rem   <= '0;
      op_q  <= '0;
      out_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= In;
            rem  <= Cnt;
            op_q <= op;
            if (Cnt == '0) out_q <= In;
          end
        end
        SHIFT: begin
          acc <= step_nx;
          rem <= rem - C'(1);
          if (rem == C'(1)) out_q <= step_nx;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    Out  = out_q;
  end

endmodule
